// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain
//   N-stage control-word pipeline from Decode to Writeback. Each stage holds a
//   control word and a valid bit. Every stage has its own hold and flush input.
//   A hold at any stage also freezes every stage upstream of it. When a stage
//   is free but its source is frozen, the stage takes a bubble. The block also
//   keeps a wrapping count of the valid words that leave the last stage.
//
// Ports
//   iclk        clock; all state changes on the rising edge
//   irst_n      asynchronous active-low reset
//   ictrl_d     control word from Decode
//   ivalid_d    ictrl_d carries a real instruction
//   ihold       per-stage hold request (bit k = stage k)
//   iflush      per-stage flush request (bit k = stage k)
//   iclr_cnt    synchronous clear of the retired counter
//   octrl       stage k word at [k*CTRL_W +: CTRL_W]
//   ovalid      stage k valid
//   oretired    count of valid words that left the last stage
//   ooccupancy  number of valid stages
module ctrl_pipe_chain #(
  parameter int CTRL_W  = 16,
  parameter int NSTAGES = 3,
  parameter int CNT_W   = 32
) (
  input  logic                         iclk,
  input  logic                         irst_n,
  input  logic [CTRL_W-1:0]            ictrl_d,
  input  logic                         ivalid_d,
  input  logic [NSTAGES-1:0]           ihold,
  input  logic [NSTAGES-1:0]           iflush,
  input  logic                         iclr_cnt,
  output logic [NSTAGES*CTRL_W-1:0]    octrl,
  output logic [NSTAGES-1:0]           ovalid,
  output logic [CNT_W-1:0]             oretired,
  output logic [$clog2(NSTAGES+1)-1:0] ooccupancy
);

  localparam int OCC_W = $clog2(NSTAGES+1);

  logic [CTRL_W-1:0]  word_q [NSTAGES];
  logic [NSTAGES-1:0] valid_q;
  logic [NSTAGES-1:0] eh;
  logic [CTRL_W-1:0]  src_word [NSTAGES];
  logic [NSTAGES-1:0] src_valid;
  logic [NSTAGES-1:0] src_hold;
  logic [CNT_W-1:0]   cnt_q;
  logic [OCC_W-1:0]   occ;

  // Effective hold: a stage is frozen if it or anything downstream holds.
  for (genvar k = 0; k < NSTAGES; k++) begin : g_eh
    assign eh[k] = |(ihold >> k);
  end

  // The source of stage 0 is the Decode input, which never holds. Invalid
  // input words are zeroed here so that the zero-word invariant holds at
  // entry to the pipeline.
  for (genvar k = 0; k < NSTAGES; k++) begin : g_src
    if (k == 0) begin : g_in
      assign src_word[k]  = ivalid_d ? ictrl_d : '0;
      assign src_valid[k] = ivalid_d;
      assign src_hold[k]  = 1'b0;
    end else begin : g_up
      assign src_word[k]  = word_q[k-1];
      assign src_valid[k] = valid_q[k-1];
      assign src_hold[k]  = eh[k-1];
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int k = 0; k < NSTAGES; k++) begin
        word_q[k]  <= '0;
        valid_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NSTAGES; k++) begin
        if (iflush[k]) begin
          word_q[k]  <= '0;
          valid_q[k] <= 1'b0;
        end else if (!eh[k]) begin
          if (src_hold[k]) begin
            // Source is frozen, so this stage takes a bubble.
            word_q[k]  <= '0;
            valid_q[k] <= 1'b0;
          end else begin
            word_q[k]  <= src_word[k];
            valid_q[k] <= src_valid[k];
          end
        end
      end
    end
  end

  // A valid last-stage word counts as retired whenever the last stage is not
  // held. A flush of that stage does not stop the count, because its word has
  // already been consumed downstream in that cycle.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      cnt_q <= '0;
    end else if (iclr_cnt) begin
      cnt_q <= '0;
    end else if (valid_q[NSTAGES-1] && !eh[NSTAGES-1]) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      occ = occ + OCC_W'(valid_q[k]);
    end
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_out
    assign octrl[k*CTRL_W +: CTRL_W] = word_q[k];
  end

  assign ovalid     = valid_q;
  assign oretired   = cnt_q;
  assign ooccupancy = occ;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
module tb_ctrl_pipe_chain;

  localparam int CW = 16;
  localparam int NS = 3;
  localparam int CN = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [CW-1:0]  ctrl_d;
  logic           valid_d;
  logic [NS-1:0]  hold;
  logic [NS-1:0]  flush;
  logic           clr_cnt;
  logic [NS*CW-1:0] octrl;
  logic [NS-1:0]  ovalid;
  logic [CN-1:0]  oretired;
  logic [1:0]     ooccupancy;

  int checks = 0;
  int errors = 0;

  ctrl_pipe_chain #(.CTRL_W(CW), .NSTAGES(NS), .CNT_W(CN)) dut (
    .iclk(clk), .irst_n(rst_n), .ictrl_d(ctrl_d), .ivalid_d(valid_d),
    .ihold(hold), .iflush(flush), .iclr_cnt(clr_cnt),
    .octrl(octrl), .ovalid(ovalid), .oretired(oretired), .ooccupancy(ooccupancy)
  );

  always #5 clk = ~clk;

  // Reference model: what each stage must hold, derived from the pipeline rules.
  int m_word [NS] = '{0, 0, 0};
  bit m_valid [NS] = '{0, 0, 0};
  int m_cnt = 0;

  always @(negedge rst_n) begin
    for (int k = 0; k < NS; k++) begin
      m_word[k] = 0;
      m_valid[k] = 0;
    end
    m_cnt = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      int ow [NS];
      bit ov [NS];
      bit frozen, src_frozen;
      for (int k = 0; k < NS; k++) begin
        ow[k] = m_word[k];
        ov[k] = m_valid[k];
      end
      for (int k = 0; k < NS; k++) begin
        frozen = 0;
        for (int j = k; j < NS; j++) if (hold[j]) frozen = 1;
        src_frozen = 0;
        if (k > 0) for (int j = k - 1; j < NS; j++) if (hold[j]) src_frozen = 1;
        if (flush[k]) begin
          m_word[k] = 0; m_valid[k] = 0;
        end else if (frozen) begin
          m_word[k] = ow[k]; m_valid[k] = ov[k];
        end else if (src_frozen) begin
          m_word[k] = 0; m_valid[k] = 0;
        end else if (k == 0) begin
          m_valid[k] = valid_d;
          m_word[k] = valid_d ? int'(ctrl_d) : 0;
        end else begin
          m_word[k] = ow[k-1]; m_valid[k] = ov[k-1];
        end
      end
      if (clr_cnt) m_cnt = 0;
      else if (ov[NS-1] && !hold[NS-1]) m_cnt = (m_cnt + 1) % (1 << CN);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int occ;
    occ = 0;
    for (int k = 0; k < NS; k++) begin
      check($sformatf("model_word%0d", k), 64'(octrl[k*CW +: CW]), 64'(m_word[k]));
      check($sformatf("model_valid%0d", k), 64'(ovalid[k]), 64'(m_valid[k]));
      occ += int'(m_valid[k]);
    end
    check("model_retired", 64'(oretired), 64'(m_cnt));
    check("model_occupancy", 64'(ooccupancy), 64'(occ));
  end

  task automatic cyc(input logic [CW-1:0] w, input logic v, input logic [NS-1:0] h,
                     input logic [NS-1:0] f, input logic c);
    ctrl_d = w; valid_d = v; hold = h; flush = f; clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] stage(input int k);
    return octrl[k*CW +: CW];
  endfunction

  int c0;

  initial begin
    rst_n = 1'b0; ctrl_d = '0; valid_d = 1'b0; hold = '0; flush = '0; clr_cnt = 1'b0;
    #12;
    check("reset_valid", 64'(ovalid), 64'h0);
    check("reset_octrl", 64'(octrl), 64'h0);
    rst_n = 1'b1;

    // Streaming latency and retirement.
    cyc(16'h0011, 1, 3'b000, 3'b000, 0);
    cyc(16'h0022, 1, 3'b000, 3'b000, 0);
    cyc(16'h0033, 1, 3'b000, 3'b000, 0);
    check("t1_edge3_stage2", 64'(stage(2)), 64'h0011);
    cyc(16'h0000, 0, 3'b000, 3'b000, 0);
    check("t1_edge4_stage2", 64'(stage(2)), 64'h0022);
    cyc(16'h0000, 0, 3'b000, 3'b000, 0);
    check("t1_edge5_stage2", 64'(stage(2)), 64'h0033);
    cyc(16'h0000, 0, 3'b000, 3'b000, 0);
    check("t1_retired", 64'(oretired), 64'd3);

    // Hold stage 1 with stage0=A, stage1=B, stage2=C.
    cyc(16'h000C, 1, 3'b000, 3'b000, 0);
    cyc(16'h000B, 1, 3'b000, 3'b000, 0);
    cyc(16'h000A, 1, 3'b000, 3'b000, 0);
    c0 = int'(oretired);
    cyc(16'h0077, 1, 3'b010, 3'b000, 0);
    cyc(16'h0077, 1, 3'b010, 3'b000, 0);
    check("t2_stage0", 64'(stage(0)), 64'h000A);
    check("t2_stage1", 64'(stage(1)), 64'h000B);
    check("t2_stage2_bubble", 64'(stage(2)), 64'h0);
    check("t2_valid", 64'(ovalid), 64'b011);
    check("t2_retired", 64'(oretired), 64'((c0 + 1) % 16));

    // Hold only the last stage: everything freezes.
    cyc(16'h0044, 1, 3'b000, 3'b000, 0);
    c0 = int'(oretired);
    cyc(16'h0099, 1, 3'b100, 3'b000, 0);
    cyc(16'h0099, 1, 3'b100, 3'b000, 0);
    check("t3_stage0", 64'(stage(0)), 64'h0044);
    check("t3_stage1", 64'(stage(1)), 64'h000A);
    check("t3_stage2", 64'(stage(2)), 64'h000B);
    check("t3_retired", 64'(oretired), 64'(c0));

    // Flush and hold of stage 0 together.
    cyc(16'h0F0F, 1, 3'b000, 3'b000, 0);
    cyc(16'h0055, 1, 3'b001, 3'b001, 0);
    check("t4_stage0", 64'(stage(0)), 64'h0);
    check("t4_stage1", 64'(stage(1)), 64'h0);
    check("t4_stage2", 64'(stage(2)), 64'h0044);
    check("t4_valid", 64'(ovalid), 64'b100);

    // Asynchronous reset mid-stream.
    cyc(16'h0101, 1, 3'b000, 3'b000, 0);
    cyc(16'h0202, 1, 3'b000, 3'b000, 0);
    cyc(16'h0303, 1, 3'b000, 3'b000, 0);
    check("t5_full", 64'(ovalid), 64'b111);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(ovalid), 64'h0);
    check("t5_rst_octrl", 64'(octrl), 64'h0);
    check("t5_rst_retired", 64'(oretired), 64'h0);
    check("t5_rst_occ", 64'(ooccupancy), 64'h0);
    #2 rst_n = 1'b1;
    cyc(16'h0505, 1, 3'b000, 3'b000, 0);
    check("t5_first_edge", 64'(stage(0)), 64'h0505);
    check("t5_first_valid", 64'(ovalid), 64'b001);
    cyc(16'h0000, 0, 3'b000, 3'b000, 0);
    cyc(16'h0000, 0, 3'b000, 3'b000, 0);
    cyc(16'h0000, 0, 3'b000, 3'b000, 1);
    check("t6_cleared", 64'(oretired), 64'h0);

    // Counter wrap and clear priority.
    for (int i = 0; i < 16; i++) cyc(CW'(16'h1000 + i), 1, 3'b000, 3'b000, 0);
    cyc(16'h0000, 0, 3'b000, 3'b000, 0);
    cyc(16'h0000, 0, 3'b000, 3'b000, 0);
    check("t6_fifteen", 64'(oretired), 64'd15);
    cyc(16'h0000, 0, 3'b000, 3'b000, 0);
    check("t6_wrap", 64'(oretired), 64'd0);
    cyc(16'h00A1, 1, 3'b000, 3'b000, 0);
    cyc(16'h00A2, 1, 3'b000, 3'b000, 0);
    cyc(16'h0000, 0, 3'b000, 3'b000, 0);
    cyc(16'h0000, 0, 3'b000, 3'b000, 0);
    check("t6_one", 64'(oretired), 64'd1);
    check("t6_pending", 64'(ovalid[2]), 64'd1);
    cyc(16'h0000, 0, 3'b000, 3'b000, 1);
    check("t6_clr_priority", 64'(oretired), 64'd0);

    // Flush of the last stage still counts as a retirement.
    cyc(16'h00B1, 1, 3'b000, 3'b000, 0);
    cyc(16'h0000, 0, 3'b000, 3'b000, 0);
    cyc(16'h0000, 0, 3'b000, 3'b000, 0);
    cyc(16'h0000, 0, 3'b000, 3'b100, 0);
    check("t7_flush_retire", 64'(oretired), 64'd1);
    check("t7_flush_valid", 64'(ovalid), 64'b000);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
